occupancy_counter: RTL and testbench
====================================

# occupancy_counter

Producer side of the room person-count interface. Watches a pair of IR beam-break sensors at the doorway: Outer beam on the corridor side, Inner beam on the room side. Classifies each full crossing as an entry or an exit and maintains the occupant count as two BCD digits (PersonTens, PersonOnes). The optimum-temperature lookup and the seven-segment display path consume this count directly.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required before a beam level is accepted (1..255).
- TIMEOUT_CYCLES, 1_000_000: maximum cycles a crossing may stay in progress before it is abandoned (≥ 2).
- MAX_PERSONS, 44: saturation ceiling for the count (1..99).

Ports:
- Clock, input, 1: the block's only clock; every register updates on the rising edge.
- Reset, input, 1: synchronous, active-high reset.
- OuterBeam, input, 1: asynchronous; 1 = beam broken.
- InnerBeam, input, 1: asynchronous; 1 = beam broken.
- ClearCount, input, 1: synchronous; forces the count to 0.
- PersonTens, output, 4: BCD tens digit of the count.
- PersonOnes, output, 4: BCD ones digit of the count.
- Full, output, 1: count == MAX_PERSONS.
- Empty, output, 1: count == 0.
- Entered, output, 1: one-cycle pulse when a valid entry is counted.
- Exited, output, 1: one-cycle pulse when a valid exit is counted.
- Overflow, output, 1: one-cycle pulse when a valid entry is rejected because the count is at MAX_PERSONS.
- Underflow, output, 1: one-cycle pulse when a valid exit is rejected because the count is 0.

## Operation
- Each beam passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: the accepted level changes only after DEBOUNCE_CYCLES consecutive samples disagree with the current accepted level. Any sample that agrees resets the run counter.
- Direction FSM runs on the debounced pair (O, I). States:
  - IDLE, waiting for a crossing:
    - O=1, I=0 → IN_1.
    - O=0, I=1 → OUT_1.
    - O=1, I=1 → ABORT.
  - Entry sequence:
    - IN_1 → IN_2 on (1,1).
    - IN_2 → IN_3 on (0,1).
    - IN_3 on (0,0) → IDLE, entry event.
  - Exit sequence:
    - OUT_1 → OUT_2 on (1,1).
    - OUT_2 → OUT_3 on (1,0).
    - OUT_3 on (0,0) → IDLE, exit event.
  - Backing out: (0,0) from IN_1/IN_2 or OUT_1/OUT_2 → IDLE, no event.
  - Reversal: IN_3 seeing (1,1) → IN_2; OUT_3 seeing (1,1) → OUT_2.
  - Any other pattern in an active state → ABORT.
  - ABORT: no event; leaves to IDLE only when (0,0).
- Timeout: a cycle counter runs in every state except IDLE. When it reaches TIMEOUT_CYCLES the FSM goes to ABORT. The counter clears on every state change.
- Count: stored as BCD digits with no binary shadow.
  - Increment: ones 9 → 0 with carry into tens.
  - Decrement: ones 0 → 9 with borrow from tens.
  - Entry event with count < MAX_PERSONS → increment, Entered=1.
  - Entry event at MAX_PERSONS → count held, Overflow=1.
  - Exit event with count > 0 → decrement, Exited=1.
  - Exit event at 0 → count held, Underflow=1.
- ClearCount: count := 0. It overrides a same-cycle event; no Entered/Exited/Overflow/Underflow pulse is produced. The FSM is unaffected.
- Full and Empty are registered and decoded from the count value the outputs currently show.
- Reset values:
  - PersonTens = PersonOnes = 0, Empty = 1.
  - Full, Entered, Exited, Overflow and Underflow = 0.
  - FSM = IDLE.
  - Debounced levels = 0; debounce, synchronizer and timeout counters = 0.
- Reset asserted mid-crossing abandons the crossing; no event is counted.

## Timing
- Raw input edge to debounced level change: 2 + DEBOUNCE_CYCLES cycles.
- FSM state follows the debounced level change on the next edge.
- The count update and its pulse are registered together, on the edge where IN_3/OUT_3 sees (0,0). PersonTens, PersonOnes, Full and Empty change on that same edge.
- Minimum dwell per beam phase is DEBOUNCE_CYCLES. Shorter glitches are invisible.
- At most one event per crossing. Back-to-back crossings are accepted with no dead time beyond the IDLE cycle.

## Structure
- Shared package occupancy_pkg holds:
  - the FSM state enum (IDLE, IN_1, IN_2, IN_3, OUT_1, OUT_2, OUT_3, ABORT);
  - the 4-bit BCD digit typedef;
  - the BCD increment/decrement functions.
- Sub-module beam_debounce contains the synchronizer and the debouncer, parameterized by DEBOUNCE_CYCLES. It is instantiated once per beam.
- The FSM, timeout counter and BCD counter stay in occupancy_counter.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and MAX_PERSONS=44.
- Reset, then drive the full entry sequence (1,0)→(1,1)→(0,1)→(0,0), each phase held 10 cycles → Entered pulses once, PersonOnes=1, Empty=0.
- From a count of 09, one entry → PersonTens=1 and PersonOnes=0. Then one exit → 0/9, Exited pulses once.
- Start at 44 and drive an entry → count stays 44, Full=1, Overflow pulses, no Entered pulse. From 0, drive an exit → Underflow pulses and the count stays 0.
- Drive a 3-cycle OuterBeam glitch → no FSM change and no event. Drive (1,0)→(0,0) as a back-out → no event.
- With TIMEOUT_CYCLES=50, hold (1,1) for 60 cycles and then release via (0,1)→(0,0) → no event. The FSM reaches ABORT at cycle 50 and returns to IDLE on (0,0).
- Assert ClearCount in the same cycle as an entry event at count 07 → count becomes 00 with no Entered pulse. Assert Reset while the FSM is in IN_2 → FSM returns to IDLE, count 0, and no event follows.

Source files
------------

// File: rtl/occupancy_pkg.sv
// occupancy_pkg: shared direction-FSM states, BCD digit types and BCD arithmetic for occupancy_counter
package occupancy_pkg;

   typedef enum logic [2:0] {IDLE, IN_1, IN_2, IN_3, OUT_1, OUT_2, OUT_3, ABORT} state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t tens;
      bcd_t ones;
   } bcd2_t;

   function automatic bcd2_t bcd_inc(input bcd2_t v);
      bcd2_t r;
      r.tens = (v.ones == 4'd9) ? v.tens + 4'd1 : v.tens;
      r.ones = (v.ones == 4'd9) ? 4'd0 : v.ones + 4'd1;
      return r;
   endfunction

   function automatic bcd2_t bcd_dec(input bcd2_t v);
      bcd2_t r;
      r.tens = (v.ones == 4'd0) ? v.tens - 4'd1 : v.tens;
      r.ones = (v.ones == 4'd0) ? 4'd9 : v.ones - 4'd1;
      return r;
   endfunction

endpackage

// File: rtl/beam_debounce.sv
// beam_debounce: 2-flop synchronizer plus run-length debouncer for one IR beam
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_raw   : asynchronous beam input, 1 = broken
//   o_level : accepted beam level
module beam_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_raw,
   output logic o_level
);

   logic [1:0] r_sync;
   logic [7:0] r_cnt;
   logic       r_level;

   // The level flips once DEBOUNCE_CYCLES consecutive synchronized samples disagree with it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_raw};
         if (r_sync[1] == r_level)
            r_cnt <= '0;
         else if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else
            r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/occupancy_counter.sv
// occupancy_counter: classifies doorway beam crossings as entries/exits and keeps a saturating BCD occupant count
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_outer_beam          : corridor-side beam, asynchronous, 1 = broken
//   i_inner_beam          : room-side beam, asynchronous, 1 = broken
//   i_clear_count         : forces the count to zero, suppresses same-cycle pulses
//   o_person_tens/ones    : BCD count digits
//   o_full, o_empty       : count == MAX_PERSONS, count == 0
//   o_entered, o_exited   : one-cycle pulses for counted entries/exits
//   o_overflow/underflow  : one-cycle pulses for rejected entries/exits
module occupancy_counter
   import occupancy_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 1_000_000,
   parameter int MAX_PERSONS     = 44
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_outer_beam,
   input  logic i_inner_beam,
   input  logic i_clear_count,
   output bcd_t o_person_tens,
   output bcd_t o_person_ones,
   output logic o_full,
   output logic o_empty,
   output logic o_entered,
   output logic o_exited,
   output logic o_overflow,
   output logic o_underflow
);

   localparam bcd2_t MAX_CNT = bcd2_t'({4'(MAX_PERSONS / 10), 4'(MAX_PERSONS % 10)});

   logic        w_o, w_i, w_to, w_ev_in, w_ev_out, w_inc, w_dec;
   logic [1:0]  w_oi;
   state_t      r_state, w_nxt;
   logic [31:0] r_tmr;
   bcd2_t       r_cnt, w_cnt;
   logic        r_full, r_empty, r_entered, r_exited, r_overflow, r_underflow;

   beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_outer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_raw   (i_outer_beam),
      .o_level (w_o)
   );

   beam_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inner (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_raw   (i_inner_beam),
      .o_level (w_i)
   );

   assign w_oi = {w_o, w_i};

   // Reversal mid-crossing (IN_3/OUT_3 seeing both beams) steps back one phase instead of aborting.
   always_comb begin
      w_nxt = ABORT;
      case (r_state)
         IDLE:    w_nxt = w_oi == 2'b10 ? IN_1 : w_oi == 2'b01 ? OUT_1 : w_oi == 2'b11 ? ABORT : IDLE;
         IN_1:    w_nxt = w_oi == 2'b00 ? IDLE : w_oi == 2'b10 ? IN_1  : w_oi == 2'b11 ? IN_2  : ABORT;
         IN_2:    w_nxt = w_oi == 2'b00 ? IDLE : w_oi == 2'b11 ? IN_2  : w_oi == 2'b01 ? IN_3  : ABORT;
         IN_3:    w_nxt = w_oi == 2'b00 ? IDLE : w_oi == 2'b01 ? IN_3  : w_oi == 2'b11 ? IN_2  : ABORT;
         OUT_1:   w_nxt = w_oi == 2'b00 ? IDLE : w_oi == 2'b01 ? OUT_1 : w_oi == 2'b11 ? OUT_2 : ABORT;
         OUT_2:   w_nxt = w_oi == 2'b00 ? IDLE : w_oi == 2'b11 ? OUT_2 : w_oi == 2'b10 ? OUT_3 : ABORT;
         OUT_3:   w_nxt = w_oi == 2'b00 ? IDLE : w_oi == 2'b10 ? OUT_3 : w_oi == 2'b11 ? OUT_2 : ABORT;
         ABORT:   w_nxt = w_oi == 2'b00 ? IDLE : ABORT;
         default: w_nxt = ABORT;
      endcase
   end

   // A genuine transition wins over a timeout landing on the same edge.
   assign w_to     = (r_state != IDLE) && (w_nxt == r_state) && (r_tmr == 32'(TIMEOUT_CYCLES - 1));
   assign w_ev_in  = (r_state == IN_3)  && (w_oi == 2'b00);
   assign w_ev_out = (r_state == OUT_3) && (w_oi == 2'b00);
   assign w_inc    = w_ev_in  && !r_full;
   assign w_dec    = w_ev_out && !r_empty;
   assign w_cnt    = i_clear_count ? bcd2_t'(8'd0) : w_inc ? bcd_inc(r_cnt) : w_dec ? bcd_dec(r_cnt) : r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_to ? ABORT : w_nxt;
         r_tmr   <= (w_to || w_nxt != r_state || r_state == IDLE) ? '0 : r_tmr + 32'd1;
      end
   end

   // Full/Empty decode the next count so they change on the same edge as the digits.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_entered   <= 1'b0;
         r_exited    <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_cnt       <= w_cnt;
         r_full      <= w_cnt == MAX_CNT;
         r_empty     <= w_cnt == bcd2_t'(8'd0);
         r_entered   <= w_inc && !i_clear_count;
         r_exited    <= w_dec && !i_clear_count;
         r_overflow  <= w_ev_in  && r_full  && !i_clear_count;
         r_underflow <= w_ev_out && r_empty && !i_clear_count;
      end
   end

   assign o_person_tens = r_cnt.tens;
   assign o_person_ones = r_cnt.ones;
   assign o_full        = r_full;
   assign o_empty       = r_empty;
   assign o_entered     = r_entered;
   assign o_exited      = r_exited;
   assign o_overflow    = r_overflow;
   assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_occupancy_counter.sv
// tb_occupancy_counter: directed crossings checked every cycle against a pattern-sequence model of the counter
module tb_occupancy_counter;
   import occupancy_pkg::*;

   localparam int D    = 4;
   localparam int TO   = 50;
   localparam int MAXP = 44;

   logic clk = 1'b0, rst = 1'b1, ob = 1'b0, ib = 1'b0, clr = 1'b0;
   logic [3:0] tens, ones;
   logic full, empty, ent, ext, ovf, unf;

   int checks = 0, failures = 0;
   int n_ent = 0, n_ext = 0, n_ovf = 0, n_unf = 0;
   bit en = 1'b0;

   // model: beam delay lines, debounce windows, crossing path summary, count
   int         m_cnt = 0, dwell = 0;
   bit         m_ent, m_ext, m_ovf, m_unf, act, bad, dir_in, ok, evi, evo;
   logic       m_lo, m_li, so, si;
   logic [1:0] m_ro, m_ri, p, last;
   logic [D-1:0] m_wo, m_wi;

   always #5 clk = ~clk;

   occupancy_counter #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(TO), .MAX_PERSONS(MAXP)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_outer_beam  (ob),
      .i_inner_beam  (ib),
      .i_clear_count (clr),
      .o_person_tens (tens),
      .o_person_ones (ones),
      .o_full        (full),
      .o_empty       (empty),
      .o_entered     (ent),
      .o_exited      (ext),
      .o_overflow    (ovf),
      .o_underflow   (unf)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Entry path: 10 then alternating 11/01, finishing on 01. Exit mirrors it with 01 and 10.
   always @(posedge clk) begin
      if (rst) begin
         m_cnt = 0; {m_ent, m_ext, m_ovf, m_unf} = 4'b0;
         m_lo = 1'b0; m_li = 1'b0; m_ro = 2'b0; m_ri = 2'b0; m_wo = '0; m_wi = '0;
         act = 1'b0; bad = 1'b0; dir_in = 1'b0; last = 2'b0; dwell = 0;
      end else begin
         p = {m_lo, m_li};
         {m_ent, m_ext, m_ovf, m_unf} = 4'b0;
         evi = 1'b0; evo = 1'b0;
         if (!act) begin
            if (p != 2'b00) begin
               act = 1'b1; bad = (p == 2'b11); dir_in = (p == 2'b10); last = p; dwell = 0;
            end
         end else if (p == 2'b00) begin
            act = 1'b0;
            evi = !bad && dir_in && last == 2'b01;
            evo = !bad && !dir_in && last == 2'b10;
         end else if (p == last) begin
            if (dwell == TO - 1) begin bad = 1'b1; dwell = 0; end
            else dwell++;
         end else begin
            ok = dir_in ? (last == 2'b11 ? p == 2'b01 : p == 2'b11) : (last == 2'b11 ? p == 2'b10 : p == 2'b11);
            if (!ok) bad = 1'b1;
            last = p; dwell = 0;
         end
         if (clr) m_cnt = 0;
         else if (evi) begin
            if (m_cnt >= MAXP) m_ovf = 1'b1;
            else begin m_cnt++; m_ent = 1'b1; end
         end else if (evo) begin
            if (m_cnt == 0) m_unf = 1'b1;
            else begin m_cnt--; m_ext = 1'b1; end
         end
         so = m_ro[1]; m_ro = {m_ro[0], ob}; m_wo = {m_wo[D-2:0], so};
         if (m_wo == {D{~m_lo}}) m_lo = ~m_lo;
         si = m_ri[1]; m_ri = {m_ri[0], ib}; m_wi = {m_wi[D-2:0], si};
         if (m_wi == {D{~m_li}}) m_li = ~m_li;
      end
   end

   always @(negedge clk) begin
      if (en) begin
         chk("outputs", 32'({tens, ones, full, empty, ent, ext, ovf, unf}),
             32'({4'(m_cnt / 10), 4'(m_cnt % 10), m_cnt == MAXP, m_cnt == 0, m_ent, m_ext, m_ovf, m_unf}));
         n_ent += int'(ent); n_ext += int'(ext); n_ovf += int'(ovf); n_unf += int'(unf);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic phase(input logic o, input logic i, input int n);
      ob = o; ib = i;
      step(n);
   endtask

   task automatic entry();
      phase(1, 0, 10); phase(1, 1, 10); phase(0, 1, 10); phase(0, 0, 10);
   endtask

   task automatic exit_room();
      phase(0, 1, 10); phase(1, 1, 10); phase(1, 0, 10); phase(0, 0, 10);
   endtask

   function automatic int pulses();
      return n_ent + n_ext + n_ovf + n_unf;
   endfunction

   initial begin
      int n, t0, e0;
      step(3);
      en = 1'b1;
      chk("rst_tens", 32'(tens), 0);
      chk("rst_ones", 32'(ones), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      rst = 1'b0;
      step(2);

      entry();
      chk("entry_ones", 32'(ones), 1);
      chk("entry_empty", 32'(empty), 0);
      chk("entry_pulses", 32'(n_ent), 1);

      repeat (8) entry();
      entry();
      chk("carry_tens", 32'(tens), 1);
      chk("carry_ones", 32'(ones), 0);
      exit_room();
      chk("borrow_tens", 32'(tens), 0);
      chk("borrow_ones", 32'(ones), 9);
      chk("exit_pulses", 32'(n_ext), 1);

      exit_room(); exit_room();
      chk("count7", 32'({tens, ones}), 32'h07);
      e0 = n_ent;
      phase(1, 0, 10); phase(1, 1, 10); phase(0, 1, 10);
      ob = 1'b0; ib = 1'b0;
      step(6);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(3);
      chk("clr_count", 32'({tens, ones}), 0);
      chk("clr_no_entered", 32'(n_ent), 32'(e0));
      chk("clr_fsm_idle", 32'(dut.r_state == IDLE), 1);

      repeat (MAXP) entry();
      chk("at_max_full", 32'(full), 1);
      e0 = n_ent;
      entry();
      chk("ovf_count", 32'({tens, ones}), 32'h44);
      chk("ovf_full", 32'(full), 1);
      chk("ovf_pulses", 32'(n_ovf), 1);
      chk("ovf_no_entered", 32'(n_ent), 32'(e0));

      clr = 1'b1; step(1); clr = 1'b0; step(1);
      exit_room();
      chk("unf_pulses", 32'(n_unf), 1);
      chk("unf_count", 32'({tens, ones}), 0);
      chk("unf_empty", 32'(empty), 1);

      t0 = pulses();
      ob = 1'b1; step(3); ob = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("glitch_idle", 32'(dut.r_state == IDLE), 1);
         step(1);
      end
      phase(1, 0, 10); phase(0, 0, 10);
      chk("backout_idle", 32'(dut.r_state == IDLE), 1);
      chk("glitch_backout_no_event", 32'(pulses()), 32'(t0));

      phase(1, 0, 10);
      ob = 1'b1; ib = 1'b1;
      n = 0;
      while (dut.r_state != IN_2 && n < 30) begin step(1); n++; end
      chk("to_reach_in2", 32'(dut.r_state == IN_2), 1);
      n = 0;
      while (dut.r_state != ABORT && n < 100) begin step(1); n++; end
      chk("to_cycles", 32'(n), 50);
      step(3);
      phase(0, 1, 10);
      chk("to_abort_hold", 32'(dut.r_state == ABORT), 1);
      phase(0, 0, 10);
      chk("to_idle", 32'(dut.r_state == IDLE), 1);
      chk("to_no_event", 32'(pulses()), 32'(t0));

      entry();
      chk("pre_rst_count", 32'({tens, ones}), 1);
      t0 = pulses();
      phase(1, 0, 10);
      ob = 1'b1; ib = 1'b1;
      n = 0;
      while (dut.r_state != IN_2 && n < 30) begin step(1); n++; end
      chk("rst_reach_in2", 32'(dut.r_state == IN_2), 1);
      rst = 1'b1; step(1); rst = 1'b0;
      chk("mid_rst_idle", 32'(dut.r_state == IDLE), 1);
      chk("mid_rst_count", 32'({tens, ones}), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      step(10);
      phase(0, 1, 10); phase(0, 0, 10);
      chk("mid_rst_no_event", 32'(pulses()), 32'(t0));
      chk("mid_rst_final_idle", 32'(dut.r_state == IDLE), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
